// File: rtl/regfile_port_sched.sv
// regfile_port_sched: shares one single-port 32x32 register file between a
// decode operand reader (rs1+rs2) and a writeback writer.
// Ports: clk, rst (async, active-high);
//   rd_valid/rd_ready, rs1_addr, rs2_addr, rs1_data, rs2_data, rd_done;
//   wb_valid/wb_ready, wb_addr, wb_data;
//   rf_register, rf_we, rf_wdata (to the RF), rf_rdata (from the RF).
// Optional macro RF_WB_BYPASS_EN: a pending write to the index being read
// supplies the operand instead of the register file.
module regfile_port_sched #(
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [31:0]       rs1_data,
  output logic [31:0]       rs2_data,
  output logic              rd_done,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [31:0]       wb_data,
  output logic [31:0]       rf_register,
  output logic              rf_we,
  output logic [31:0]       rf_wdata,
  input  logic [31:0]       rf_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD1  = 2'd2,
    RD2  = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            r_state;
  logic [3:0]        r_starve_cnt;
  logic [ADDR_W-1:0] r_rf_reg;
  logic              r_rf_we;
  logic [31:0]       r_rf_wdata;
  logic [ADDR_W-1:0] r_rs2_addr;
  logic [31:0]       r_rs1_data;
  logic [31:0]       r_rs2_data;
  logic              r_rd_done;

  logic              w_idle;
  logic              w_starved;
  logic              w_wb_ready;
  logic              w_rd_ready;
  logic [31:0]       w_rd_op;

  assign w_idle     = (r_state == IDLE);
  assign w_starved  = rd_valid & (r_starve_cnt == LIMIT);
  assign w_wb_ready = w_idle & wb_valid & ~w_starved;
  assign w_rd_ready = w_idle & rd_valid & ~w_wb_ready;

  // r_rf_reg holds the index currently on the port in RD1/RD2.
`ifdef RF_WB_BYPASS_EN
  assign w_rd_op = (wb_valid && (wb_addr == r_rf_reg) && (|r_rf_reg))
                 ? wb_data : rf_rdata;
`else
  assign w_rd_op = rf_rdata;
`endif

  assign wb_ready    = w_wb_ready;
  assign rd_ready    = w_rd_ready;
  assign rf_register = {{(32-ADDR_W){1'b0}}, r_rf_reg};
  assign rf_we       = r_rf_we;
  assign rf_wdata    = r_rf_wdata;
  assign rs1_data    = r_rs1_data;
  assign rs2_data    = r_rs2_data;
  assign rd_done     = r_rd_done;

  // Port outputs are loaded on entry to each state so they are registered
  // and still drop immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_rf_reg     <= '0;
      r_rf_we      <= 1'b0;
      r_rf_wdata   <= '0;
      r_rs2_addr   <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_rd_done    <= 1'b0;
    end else begin
      r_rd_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_wb_ready) begin
            r_state    <= WR;
            r_rf_reg   <= wb_addr;
            r_rf_we    <= |wb_addr;
            r_rf_wdata <= wb_data;
            if (rd_valid && (r_starve_cnt != LIMIT))
              r_starve_cnt <= r_starve_cnt + 4'd1;
          end else if (w_rd_ready) begin
            r_state      <= RD1;
            r_rf_reg     <= rs1_addr;
            r_rs2_addr   <= rs2_addr;
            r_starve_cnt <= '0;
          end
        end
        WR: begin
          r_state    <= IDLE;
          r_rf_reg   <= '0;
          r_rf_we    <= 1'b0;
          r_rf_wdata <= '0;
        end
        RD1: begin
          r_state    <= RD2;
          r_rs1_data <= w_rd_op;
          r_rf_reg   <= r_rs2_addr;
        end
        RD2: begin
          r_state    <= IDLE;
          r_rs2_data <= w_rd_op;
          r_rd_done  <= 1'b1;
          r_rf_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_sched.sv
// tb_regfile_port_sched: directed vectors for regfile_port_sched with a
// behavioural single-port register file attached.
module tb_regfile_port_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_valid, rd_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rd_done;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] rf_register;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata;

  logic [31:0] mem [32];

  int n_vec = 0;
  int n_err = 0;

  logic [4:0]  wa [8];
  logic [31:0] wd [8];
  logic [31:0] got1, got2;
  int          wbefore;

  always #5 clk = ~clk;

  regfile_port_sched dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_done(rd_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_register(rf_register), .rf_we(rf_we),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  always @(posedge clk)
    if (rf_we) mem[rf_register[4:0]] <= rf_wdata;
  assign rf_rdata = mem[rf_register[4:0]];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    rd_valid = 0; wb_valid = 0;
    rs1_addr = 0; rs2_addr = 0;
    wb_addr = 0; wb_data = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_valid = 1; wb_addr = a; wb_data = d;
    #1 check("wr_ready", 32'(wb_ready), 1);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    check("wr_reg", rf_register, 32'(a));
    check("wr_we", 32'(rf_we), 32'(a != 0));
    check("wr_data", rf_wdata, d);
    @(posedge clk);
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                    input logic [31:0] e1, input logic [31:0] e2);
    @(negedge clk);
    rd_valid = 1; rs1_addr = a1; rs2_addr = a2;
    #1 check("rd_ready", 32'(rd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    check("rd1_reg", rf_register, 32'(a1));
    check("rd1_done", 32'(rd_done), 0);
    @(negedge clk);
    check("rd2_reg", rf_register, 32'(a2));
    check("rd2_done", 32'(rd_done), 0);
    @(negedge clk);
    check("rd_done", 32'(rd_done), 1);
    check("rd_rs1", rs1_data, e1);
    check("rd_rs2", rs2_data, e2);
    @(negedge clk);
    check("rd_done_clr", 32'(rd_done), 0);
  endtask

  // Writes wa/wd[0..nw-1] back-to-back while one read waits.
  task automatic mix(input int nw, input logic [4:0] a1,
                     input logic [4:0] a2, output int wb4);
    int  widx = 0;
    bit  racc = 0;
    bit  dseen = 0;
    bit  w, r;
    wb4 = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (widx == nw && dseen) break;
      @(negedge clk);
      if (rd_done) begin
        dseen = 1; got1 = rs1_data; got2 = rs2_data;
      end
      wb_valid = (widx < nw);
      wb_addr  = wa[widx];
      wb_data  = wd[widx];
      rd_valid = !racc;
      rs1_addr = a1; rs2_addr = a2;
      #1;
      w = wb_ready; r = rd_ready;
      @(posedge clk);
      if (w) widx++;
      if (r) begin racc = 1; wb4 = widx; end
    end
    check("mix_complete", 32'(widx == nw && dseen), 1);
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 0;
    drive_idle();
    rst = 1;
    repeat (2) @(negedge clk);
    check("rst_rs1", rs1_data, 0);
    check("rst_rs2", rs2_data, 0);
    check("rst_done", 32'(rd_done), 0);
    check("rst_reg", rf_register, 0);
    check("rst_we", 32'(rf_we), 0);
    check("rst_wdata", rf_wdata, 0);
    rst = 0;

    wr(5, 32'hDEADBEEF);
    rd(5, 0, 32'hDEADBEEF, 0);

    wr(0, 32'h12345678);
    rd(0, 5, 0, 32'hDEADBEEF);

    for (int i = 0; i < 6; i++) begin
      wa[i] = 5'(10 + i); wd[i] = 32'hA0 + i;
    end
    mix(6, 10, 13, wbefore);
    check("starve1_wbefore", 32'(wbefore), 4);
    check("starve1_rs1", got1, 32'hA0);
    check("starve1_rs2", got2, 32'hA3);

    for (int i = 0; i < 6; i++) wd[i] = 32'hB0 + i;
    mix(6, 14, 15, wbefore);
    check("starve2_wbefore", 32'(wbefore), 4);
    check("starve2_rs1", got1, 32'hA4);
    check("starve2_rs2", got2, 32'hA5);
    rd(14, 10, 32'hB4, 32'hB0);

    wr(7, 32'h55);
    @(negedge clk);
    wb_valid = 1; wb_addr = 7; wb_data = 32'hAA;
    @(posedge clk);
    #1 check("rstwr_we_on", 32'(rf_we), 1);
    drive_idle();
    #1 rst = 1;
    #1;
    check("rstwr_we", 32'(rf_we), 0);
    check("rstwr_reg", rf_register, 0);
    check("rstwr_wdata", rf_wdata, 0);
    check("rstwr_rs1", rs1_data, 0);
    check("rstwr_done", 32'(rd_done), 0);
    @(negedge clk);
    rst = 0;
    rd(7, 0, 32'h55, 0);

    wr(3, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wa[i] = 5'(20 + i); wd[i] = 32'hC0 + i;
    end
    wa[4] = 3; wd[4] = 32'h2;
    mix(5, 3, 20, wbefore);
    check("byp_wbefore", 32'(wbefore), 4);
`ifdef RF_WB_BYPASS_EN
    check("byp_rs1", got1, 32'h2);
`else
    check("byp_rs1", got1, 32'h1);
`endif
    check("byp_rs2", got2, 32'hC0);
    rd(3, 23, 32'h2, 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_port_sched.md
Name: regfile_port_sched

Overview:
- Scheduler that shares the single-port 32x32 register file between a decode-side operand read requester (two source registers) and a writeback-side write requester.
- Serialises each request onto the one address/write port: one write cycle per writeback, two read cycles per operand fetch.
- Captures both operands and signals completion with a one-cycle done pulse.
- Sits between the decode/writeback stages and the register file instance.

Parameters:
- ADDR_W, 5, register index width; rf_register is zero-extended to 32 bits.
- STARVE_LIMIT, 4, consecutive writes granted while a read waits before the read is forced through. Legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rd_valid  input  1  operand read request.
- rd_ready  output  1  read request accepted this cycle.
- rs1_addr  input  ADDR_W  first source index.
- rs2_addr  input  ADDR_W  second source index.
- rs1_data  output  32  captured rs1 operand.
- rs2_data  output  32  captured rs2 operand.
- rd_done  output  1  one-cycle pulse: both operands valid.
- wb_valid  input  1  write request.
- wb_ready  output  1  write request accepted this cycle.
- wb_addr  input  ADDR_W  destination index.
- wb_data  input  32  write data.
- rf_register  output  32  register-file index (zero-extended).
- rf_we  output  1  register-file write enable.
- rf_wdata  output  32  register-file write data.
- rf_rdata  input  32  register-file combinational read data.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, starve_cnt=0, rs1_data=0, rs2_data=0, rd_done=0, captured addresses/data=0.
  - Derived outputs during reset: rf_register=0, rf_we=0, rf_wdata=0.
  - Reset mid-operation abandons the request; a write in WR is not performed because rf_we drops at once.
- FSM states: IDLE, WR, RD1, RD2.
- Readiness (combinational):
  - wb_ready = IDLE & wb_valid & !(rd_valid & starve_cnt==STARVE_LIMIT).
  - rd_ready = IDLE & rd_valid & !wb_ready.
  - Writes win ties unless the starvation limit is reached.
- IDLE:
  - On write accept: capture wb_addr/wb_data, go to WR.
  - On read accept: capture rs1_addr/rs2_addr, go to RD1.
  - Otherwise stay.
  - Port signals: rf_register=0, rf_we=0.
- WR:
  - Port signals: rf_register=captured wb_addr, rf_wdata=captured data.
  - rf_we=1 unless wb_addr==0; writes to x0 are accepted and completed with rf_we=0.
  - Next state: IDLE.
- RD1: rf_register=rs1 index; at the clock edge rs1_data<=rf_rdata. Next state: RD2.
- RD2: rf_register=rs2 index; at the clock edge rs2_data<=rf_rdata and rd_done<=1. Next state: IDLE.
- rd_done:
  - High only during the cycle after RD2, and cleared in every other cycle.
  - A new request may be accepted in that same cycle.
  - rs1_data/rs2_data hold until overwritten by the next RD1/RD2.
- Latency:
  - Write: accept edge plus one WR cycle.
  - Read: rd_done is high 2 cycles after the accept edge.
  - Throughput: 2 cycles per write, 3 cycles per read.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each write accept made while rd_valid=1.
  - Clears on every read accept.
  - Otherwise unchanged.
- Outside WR, rf_we=0 and rf_wdata=0.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined: in RD1/RD2, if wb_valid=1, wb_addr equals the index being read, and that index is non-zero, the captured operand is wb_data instead of rf_rdata. The write stays pending and is scheduled normally later.
- Undefined: operands always come from rf_rdata.

Test Plan:
- Write then read: assert rst, release; write x5=0xDEADBEEF, then read rs1=5, rs2=0 -> one WR cycle with rf_we=1 and rf_register=5; rd_done exactly 2 cycles after read accept; rs1_data=0xDEADBEEF, rs2_data=0.
- x0 write: write x0=0x12345678 -> wb_ready pulses; rf_we stays 0 throughout; a later read of x0 returns 0.
- Starvation: hold wb_valid with 6 back-to-back writes while rd_valid=1 (STARVE_LIMIT=4) -> exactly 4 writes granted, then the read is granted; starve_cnt returns to 0; remaining writes follow.
- Reset in WR: assert rst during WR of x7=0xAA -> rf_we falls immediately; all outputs return to reset values; a later read of x7 returns the old value.
- Bypass: with RF_WB_BYPASS_EN defined, x3 holds 0x1; hold wb_valid with x3=0x2 during RD1 of a read accepted at the starvation limit -> rs1_data=0x2. With the macro undefined -> rs1_data=0x1.
